// File: rtl/peripheral_dbg_pu_or1k_tap_if.sv
// JTAG pin and debug-top signal bundle for the OR1K TAP controller.
// The slave modport is the TAP itself; the master modport is whatever drives the TAP pins.
interface peripheral_dbg_pu_or1k_tap_if;
    logic tms_i;
    logic tdi_i;
    logic tdo_o;
    logic tdo_oe_o;
    logic debug_tdo_i;
    logic bs_chain_tdo_i;
    logic mbist_tdo_i;
    logic test_logic_reset_o;
    logic run_test_idle_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic pause_dr_o;
    logic update_dr_o;
    logic debug_select_o;
    logic extest_select_o;
    logic sample_preload_select_o;
    logic mbist_select_o;

    modport slave (
        input  tms_i, tdi_i, debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i,
        output tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
               capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
               debug_select_o, extest_select_o, sample_preload_select_o, mbist_select_o
    );

    modport master (
        output tms_i, tdi_i, debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i,
        input  tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
               capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
               debug_select_o, extest_select_o, sample_preload_select_o, mbist_select_o
    );
endinterface

// File: rtl/peripheral_dbg_pu_or1k_tap.sv
// IEEE 1149.1 TAP controller feeding the OR1K debug top: TAP FSM, IR, IDCODE/BYPASS DRs, TDO mux.
// Define PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN to decode the MBIST instruction and route mbist_tdo_i.
module peripheral_dbg_pu_or1k_tap #(
    parameter int unsigned IR_LENGTH    = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
    input logic                         tck_i,
    input logic                         rst_i,
    peripheral_dbg_pu_or1k_tap_if.slave tap
);

    localparam logic [IR_LENGTH-1:0] INSTR_EXTEST         = 'b0000;
    localparam logic [IR_LENGTH-1:0] INSTR_SAMPLE_PRELOAD = 'b0001;
    localparam logic [IR_LENGTH-1:0] INSTR_IDCODE         = 'b0010;
    localparam logic [IR_LENGTH-1:0] INSTR_DEBUG          = 'b1000;
`ifdef PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN
    localparam logic [IR_LENGTH-1:0] INSTR_MBIST          = 'b1001;
`endif
    localparam logic [IR_LENGTH-1:0] IR_CAPTURE           = 'b0101;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e           state_q, state_d;
    logic [IR_LENGTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LENGTH-1:0] ir_latched_q, ir_latched_d;
    logic [31:0]          id_q, id_d;
    logic                 bypass_q, bypass_d;
    logic                 tdo_q, tdo_d;
    logic                 tdo_oe_q, tdo_oe_d;

    logic sel_idcode;
    logic sel_debug;
    logic sel_extest;
    logic sel_sample;
    logic sel_mbist;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TLR;
            ir_shift_q <= '0;
            id_q       <= '0;
            bypass_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_shift_q <= ir_shift_d;
            id_q       <= id_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tap.tms_i ? TLR    : RTI;
            RTI:     state_d = tap.tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tap.tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tap.tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tap.tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tap.tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tap.tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tap.tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tap.tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tap.tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tap.tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tap.tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tap.tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tap.tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tap.tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tap.tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Instruction decode works on the latched IR, so selects stay stable through DR scans.
    always_comb begin
        sel_idcode = (ir_latched_q == INSTR_IDCODE);
        sel_debug  = (ir_latched_q == INSTR_DEBUG);
        sel_extest = (ir_latched_q == INSTR_EXTEST);
        sel_sample = (ir_latched_q == INSTR_SAMPLE_PRELOAD);
`ifdef PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN
        sel_mbist  = (ir_latched_q == INSTR_MBIST);
`else
        sel_mbist  = 1'b0;
`endif
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        id_d       = id_q;
        bypass_d   = bypass_q;
        case (state_q)
            CAP_IR: ir_shift_d = IR_CAPTURE;
            SH_IR:  ir_shift_d = {tap.tdi_i, ir_shift_q[IR_LENGTH-1:1]};
            CAP_DR: begin
                bypass_d = 1'b0;
                if (sel_idcode) begin
                    id_d = IDCODE_VALUE;
                end
            end
            SH_DR: begin
                bypass_d = tap.tdi_i;
                if (sel_idcode) begin
                    id_d = {tap.tdi_i, id_q[31:1]};
                end
            end
            default: ;
        endcase
    end

    // Negedge side: IR update and TDO launch happen half a cycle ahead of the next posedge.
    always_comb begin
        ir_latched_d = ir_latched_q;
        if (state_q == TLR) begin
            ir_latched_d = INSTR_IDCODE;
        end else if (state_q == UPD_IR) begin
            ir_latched_d = ir_shift_q;
        end

        tdo_d = 1'b0;
        case (state_q)
            SH_IR: tdo_d = ir_shift_q[0];
            SH_DR: begin
                if (sel_idcode) begin
                    tdo_d = id_q[0];
                end else if (sel_debug) begin
                    tdo_d = tap.debug_tdo_i;
                end else if (sel_extest || sel_sample) begin
                    tdo_d = tap.bs_chain_tdo_i;
`ifdef PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN
                end else if (sel_mbist) begin
                    tdo_d = tap.mbist_tdo_i;
`endif
                end else begin
                    tdo_d = bypass_q;
                end
            end
            default: ;
        endcase

        tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
    end

    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            ir_latched_q <= INSTR_IDCODE;
            tdo_q        <= 1'b0;
            tdo_oe_q     <= 1'b0;
        end else begin
            ir_latched_q <= ir_latched_d;
            tdo_q        <= tdo_d;
            tdo_oe_q     <= tdo_oe_d;
        end
    end

`ifndef PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN
    logic unused_mbist_tdo;
    assign unused_mbist_tdo = tap.mbist_tdo_i;
`endif

    assign tap.tdo_o                   = tdo_q;
    assign tap.tdo_oe_o                = tdo_oe_q;
    assign tap.test_logic_reset_o      = (state_q == TLR);
    assign tap.run_test_idle_o         = (state_q == RTI);
    assign tap.capture_dr_o            = (state_q == CAP_DR);
    assign tap.shift_dr_o              = (state_q == SH_DR);
    assign tap.pause_dr_o              = (state_q == PA_DR);
    assign tap.update_dr_o             = (state_q == UPD_DR);
    assign tap.debug_select_o          = sel_debug;
    assign tap.extest_select_o         = sel_extest;
    assign tap.sample_preload_select_o = sel_sample;
    assign tap.mbist_select_o          = sel_mbist;

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_tap.sv
// Scoreboard bench for the OR1K TAP: walks the TAP FSM, scans IR/DR chains and checks TDO.
// Inputs change and outputs are sampled one time unit after each negedge of tck.
module tb_peripheral_dbg_pu_or1k_tap;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    logic tck = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    logic exp_q[$];

    peripheral_dbg_pu_or1k_tap_if tap_if ();

    peripheral_dbg_pu_or1k_tap #(
        .IR_LENGTH   (4),
        .IDCODE_VALUE(IDCODE)
    ) dut (
        .tck_i(tck),
        .rst_i(rst),
        .tap  (tap_if)
    );

    always #5 tck = ~tck;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input string tag, input logic observed);
        if (exp_q.size() == 0) begin
            checkOutput(tag, 32'(observed), 'x);
        end else begin
            checkOutput(tag, 32'(observed), 32'(exp_q.pop_front()));
        end
    endtask

    function automatic logic [31:0] selVec();
        return 32'({tap_if.debug_select_o, tap_if.extest_select_o,
                    tap_if.sample_preload_select_o, tap_if.mbist_select_o});
    endfunction

    task automatic applyStimulus(input logic tms, input logic tdi);
        tap_if.tms_i = tms;
        tap_if.tdi_i = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Target chain gets v, the other two get ~v so a wrong TDO mux leg always shows.
    task automatic driveChain(input int which, input logic v);
        tap_if.debug_tdo_i    = ~v;
        tap_if.bs_chain_tdo_i = ~v;
        tap_if.mbist_tdo_i    = ~v;
        case (which)
            0:       tap_if.debug_tdo_i    = v;
            1:       tap_if.bs_chain_tdo_i = v;
            default: tap_if.mbist_tdo_i    = v;
        endcase
    endtask

    task automatic enterShiftDr();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("capture_dr", 32'(tap_if.capture_dr_o), 32'd1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic enterShiftIr();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic loadIr(input logic [3:0] code);
        enterShiftIr();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, code[i]);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic readIdcode();
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        enterShiftDr();
        for (int i = 0; i < 32; i++) begin
            popCheck("idcode_bit", tap_if.tdo_o);
            applyStimulus(i == 31, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic shiftBypass(input logic [7:0] pattern, input int n);
        exp_q.push_back(1'b0);
        enterShiftDr();
        for (int i = 0; i < n; i++) begin
            popCheck("bypass_tdo", tap_if.tdo_o);
            checkOutput("bypass_oe", 32'(tap_if.tdo_oe_o), 32'd1);
            if (i < n - 1) exp_q.push_back(pattern[i]);
            applyStimulus(i == n - 1, pattern[i]);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("pause_dr", 32'(tap_if.pause_dr_o), 32'd1);
        checkOutput("pause_oe", 32'(tap_if.tdo_oe_o), 32'd0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("update_dr", 32'(tap_if.update_dr_o), 32'd1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic shiftChain(input int n, input int which, input logic do_exit);
        logic v;
        v = 1'($urandom_range(0, 1));
        driveChain(which, v);
        exp_q.push_back(v);
        enterShiftDr();
        for (int i = 0; i < n; i++) begin
            popCheck("chain_tdo", tap_if.tdo_o);
            checkOutput("shift_dr", 32'(tap_if.shift_dr_o), 32'd1);
            v = 1'($urandom_range(0, 1));
            driveChain(which, v);
            if (!(do_exit && i == n - 1)) exp_q.push_back(v);
            applyStimulus(do_exit && i == n - 1, 1'($urandom_range(0, 1)));
        end
        if (do_exit) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("update_dr", 32'(tap_if.update_dr_o), 32'd1);
            applyStimulus(1'b0, 1'b0);
            checkOutput("shift_dr_idle", 32'(tap_if.shift_dr_o), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tap_if.tms_i          = 1'b1;
        tap_if.tdi_i          = 1'b0;
        tap_if.debug_tdo_i    = 1'b0;
        tap_if.bs_chain_tdo_i = 1'b0;
        tap_if.mbist_tdo_i    = 1'b0;
        @(negedge tck);
        #1;
        checkOutput("rst_tlr", 32'(tap_if.test_logic_reset_o), 32'd1);
        checkOutput("rst_strobes", 32'({tap_if.run_test_idle_o, tap_if.capture_dr_o, tap_if.shift_dr_o,
                                        tap_if.pause_dr_o, tap_if.update_dr_o}), 32'd0);
        checkOutput("rst_selects", selVec(), 32'd0);
        checkOutput("rst_tdo", 32'({tap_if.tdo_o, tap_if.tdo_oe_o}), 32'd0);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0);
        checkOutput("rti", 32'(tap_if.run_test_idle_o), 32'd1);
        readIdcode();

        // IR capture pattern, shifting in 1111 so the update selects BYPASS.
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        enterShiftIr();
        for (int i = 0; i < 4; i++) begin
            popCheck("ir_capture", tap_if.tdo_o);
            checkOutput("ir_oe", 32'(tap_if.tdo_oe_o), 32'd1);
            applyStimulus(i == 3, 1'b1);
        end
        checkOutput("ir_exit_oe", 32'(tap_if.tdo_oe_o), 32'd0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("bypass_sel", selVec(), 32'd0);
        shiftBypass(8'b0000_1101, 4);

        loadIr(4'b0000);
        checkOutput("extest_sel", selVec(), 32'b0100);
        shiftChain(6, 1, 1'b1);

        loadIr(4'b0001);
        checkOutput("sample_sel", selVec(), 32'b0010);
        shiftChain(5, 1, 1'b1);

        loadIr(4'b1001);
`ifdef PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN
        checkOutput("mbist_sel", selVec(), 32'b0001);
        shiftChain(5, 2, 1'b1);
`else
        checkOutput("mbist_sel", selVec(), 32'd0);
        tap_if.mbist_tdo_i = 1'b1;
        shiftBypass(8'b0000_0110, 3);
`endif

        // TLR from Shift-IR: the partial IR (1010) passes through Update-IR, then TLR forces IDCODE.
        loadIr(4'b1000);
        checkOutput("debug_sel", selVec(), 32'b1000);
        enterShiftIr();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("tlr_5tms", 32'(tap_if.test_logic_reset_o), 32'd1);
        checkOutput("tlr_selects", selVec(), 32'd0);
        applyStimulus(1'b0, 1'b0);
        readIdcode();

        // Reset in the middle of a DEBUG scan.
        loadIr(4'b1000);
        checkOutput("debug_sel2", selVec(), 32'b1000);
        shiftChain(10, 0, 1'b0);
        tap_if.tms_i = 1'b1;
        rst = 1'b1;
        #2;
        checkOutput("midrst_tlr", 32'(tap_if.test_logic_reset_o), 32'd1);
        checkOutput("midrst_shift", 32'(tap_if.shift_dr_o), 32'd0);
        checkOutput("midrst_sel", selVec(), 32'd0);
        checkOutput("midrst_oe", 32'(tap_if.tdo_oe_o), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge tck);
        #1;
        applyStimulus(1'b0, 1'b0);
        readIdcode();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/peripheral_dbg_pu_or1k_tap.md
Name: peripheral_dbg_pu_or1k_tap

Overview:
- IEEE 1149.1 TAP controller sitting directly upstream of the OR1K debug top.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register, IDCODE register and BYPASS register.
- Drives the DR-phase strobes (capture/shift/pause/update) and the debug-chain select consumed by the debug top.
- Muxes TDO between its own registers and the debug-chain TDO.

Parameters:
- IR_LENGTH, 4, instruction register width; fixed at 4, other values unsupported.
- IDCODE_VALUE, 32'h149511C3, value loaded into the IDCODE DR at Capture-DR; bit 0 must be 1.

Ports:
- tck_i  in  1  JTAG test clock
- rst_i  in  1  reset: asynchronous, active-high; TRST-equivalent
- tms_i  in  1  test mode select, sampled on posedge tck_i
- tdi_i  in  1  test data in
- tdo_o  out  1  test data out, updated on negedge tck_i
- tdo_oe_o  out  1  TDO output enable
- debug_tdo_i  in  1  TDO from the debug top
- bs_chain_tdo_i  in  1  TDO from the boundary-scan chain
- mbist_tdo_i  in  1  TDO from the MBIST chain (optional feature only)
- test_logic_reset_o  out  1  FSM in Test-Logic-Reset
- run_test_idle_o  out  1  FSM in Run-Test/Idle
- capture_dr_o  out  1  FSM in Capture-DR
- shift_dr_o  out  1  FSM in Shift-DR
- pause_dr_o  out  1  FSM in Pause-DR
- update_dr_o  out  1  FSM in Update-DR
- debug_select_o  out  1  latched IR == DEBUG
- extest_select_o  out  1  latched IR == EXTEST
- sample_preload_select_o  out  1  latched IR == SAMPLE_PRELOAD
- mbist_select_o  out  1  latched IR == MBIST

Behaviour:
- Instruction codes:
  - EXTEST 4'b0000
  - SAMPLE_PRELOAD 4'b0001
  - IDCODE 4'b0010
  - DEBUG 4'b1000
  - MBIST 4'b1001
  - BYPASS 4'b1111
  - Any other code behaves as BYPASS.
- FSM:
  - 16 standard states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
  - State register advances on posedge tck_i using the 1149.1 TMS transition table.
  - Five consecutive TMS=1 samples reach TLR from any state.
- State outputs are a combinational decode of the state register, so the debug top sees shift_dr_o high on exactly the posedges on which it must shift.
- Instruction register path:
  - IR shift register, posedge: CAP_IR loads 4'b0101 (LSBs 01 mandatory); SH_IR shifts {tdi_i, ir[3:1]}.
  - Latched IR is written on negedge tck_i while in UPD_IR.
  - In TLR (and on reset) the latched IR is IDCODE; the select outputs decode it directly.
- IDCODE DR: CAP_DR with IDCODE loads IDCODE_VALUE; SH_DR shifts {tdi_i, id[31:1]}.
- BYPASS DR: 1 bit. CAP_DR loads 0; SH_DR loads tdi_i. Gives a one-TCK delay from TDI to TDO.
- TDO mux (registered on negedge tck_i):
  - SH_IR: ir_shift[0].
  - SH_DR: per latched IR — IDCODE gives id[0], DEBUG gives debug_tdo_i, EXTEST/SAMPLE_PRELOAD give bs_chain_tdo_i, MBIST gives mbist_tdo_i, otherwise bypass.
  - Any other state: 0.
- tdo_oe_o is registered on negedge tck_i: 1 iff the state is SH_IR or SH_DR.
- Reset (asynchronous, overrides all):
  - state = TLR, ir_shift = 0, latched IR = IDCODE, id/bypass = 0, tdo_o = 0, tdo_oe_o = 0.
  - Resulting outputs: test_logic_reset_o = 1, other state strobes 0, all selects 0 (IDCODE is not a select).
  - Reset asserted mid-shift discards the partial IR/DR contents; the latched IR does not take the partial value.
- Simultaneous events: the IR update on negedge in UPD_IR completes before the next posedge transition, so a new select is valid on the first posedge after UPD_IR.

Optional Feature:
- Macro: PERIPHERAL_DBG_PU_OR1K_TAP_MBIST_EN.
- Defined: MBIST (4'b1001) is decoded; mbist_select_o asserts while it is latched; SH_DR muxes mbist_tdo_i to TDO.
- Undefined: 4'b1001 behaves as BYPASS; mbist_select_o tied 0; mbist_tdo_i ignored. Ports remain present in both builds.

Test Plan:
- Pulse rst_i, TMS to SH_DR, shift 32 bits with TDI=0 -> TDO sequence LSB-first equals 32'h149511C3, no UPD_IR needed.
- From SH_IR, hold TMS=1 for 5 TCK -> test_logic_reset_o=1; latched IR reads back as IDCODE.
- Load IR=4'b1111, shift TDI pattern 1,0,1,1 in SH_DR -> TDO shows 0,1,0,1 (one-bit delay, leading capture 0).
- Enter CAP_IR then SH_IR, shift 4 bits -> TDO emits 1,0,1,0 (4'b0101 LSB first); tdo_oe_o high only during the shift.
- Load IR=4'b1000 -> debug_select_o=1 from the first posedge after UPD_IR; in SH_DR, tdo_o mirrors debug_tdo_i delayed to negedge; shift_dr_o high only in SH_DR.
- Assert rst_i during SH_DR after 10 bits of IR=DEBUG -> immediately TLR, debug_select_o=0, tdo_oe_o=0, IR=IDCODE.
